// File: rtl/vaelix_sequence_gate.sv
// -----------------------------------------------------------------------------
// vaelix_sequence_gate
//
// Multi-digit key-sequence lock for the perimeter gate front panel. A key
// sequence of KEY_LEN digits (KEY_W bits each) is entered one digit per rising
// edge of key_strobe. Digit 0 lives in KEY[KEY_W-1:0] and is entered first.
// A wrong sequence bumps a consecutive-fail counter; reaching MAX_FAIL starts a
// timed lockout. A correct sequence opens the gate, optionally for a limited
// window. Any change on the tamper bus latches BRICK, which only a power-state
// cycle (ena low) can clear.
//
// Ports
//   clk         in   1         system clock
//   rst_n       in   1         synchronous active-low reset (keeps BRICK)
//   ena         in   1         power-state enable; low clears everything
//   key_in      in   KEY_W     digit presented with the strobe
//   key_strobe  in   1         digit submit, rising edge detected internally
//   relock      in   1         level, forces UNLOCKED back to LOCKED
//   tamper_in   in   TAMPER_W  probe-monitor bus, any toggle is a tamper event
//   seg_out     out  8         7-seg {dp,g,f,e,d,c,b,a}, active-low
//   glow_out    out  8         status array
//   unlocked    out  1         high in UNLOCKED
//   bricked     out  1         high in BRICK
//
// Strobe handshake: a digit is consumed on the first clk edge that samples
// key_strobe=1 after an edge that sampled it 0, and only while the FSM is in
// LOCKED or COLLECT. Holding the strobe high consumes exactly one digit; there
// is no back-pressure, strobes in other states are simply dropped while the
// edge detector keeps tracking the line.
//
// All outputs are decoded from registered state only (including a registered
// copy of ena), so key_in / tamper_in / ena never reach an output
// combinationally.
// -----------------------------------------------------------------------------
module vaelix_sequence_gate #(
    parameter int                         KEY_W       = 8,
    parameter int                         KEY_LEN     = 4,
    parameter logic [KEY_LEN*KEY_W-1:0]   KEY         = 32'hB65AC317,
    parameter int                         MAX_FAIL    = 3,
    parameter int                         LOCKOUT_CYC = 1024,
    parameter int                         UNLOCK_CYC  = 0,
    parameter int                         TAMPER_W    = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic [KEY_W-1:0]    key_in,
    input  logic                key_strobe,
    input  logic                relock,
    input  logic [TAMPER_W-1:0] tamper_in,
    output logic [7:0]          seg_out,
    output logic [7:0]          glow_out,
    output logic                unlocked,
    output logic                bricked
);

    // -------------------------------------------------------------------------
    // Local constants
    // -------------------------------------------------------------------------
    localparam int IDX_W = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(KEY_LEN - 1);

    localparam logic [31:0] UNLOCK_LAST  = 32'(UNLOCK_CYC - 1);
    localparam logic [31:0] LOCKOUT_LAST = 32'(LOCKOUT_CYC - 1);
    localparam logic [8:0]  FAIL_LIMIT   = 9'(MAX_FAIL);

    // 7-segment glyphs, active-low {dp,g,f,e,d,c,b,a}
    localparam logic [7:0] SEG_OFF      = 8'hFF;
    localparam logic [7:0] SEG_LOCKED   = 8'hC7;  // 'L'
    localparam logic [7:0] SEG_COLLECT  = 8'hBF;  // '-'
    localparam logic [7:0] SEG_UNLOCKED = 8'hC1;  // 'U'
    localparam logic [7:0] SEG_LOCKOUT  = 8'h86;  // 'E'
    localparam logic [7:0] SEG_BRICK    = 8'h00;  // every segment lit

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_LOCKED   = 3'd0,
        ST_COLLECT  = 3'd1,
        ST_UNLOCKED = 3'd2,
        ST_LOCKOUT  = 3'd3,
        ST_BRICK    = 3'd4
    } state_t;

    // state_q is the single point of truth for the FSM and is the signal to
    // probe when looking at the controller from outside.
    state_t                state_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  mismatch_q;
    logic [7:0]            fail_cnt_q;
    logic [31:0]           timer_q;
    logic                  strobe_prev_q;
    logic [TAMPER_W-1:0]   tamper_prev_q;
    logic                  power_q;     // registered ena, drives the "off" decode

    // -------------------------------------------------------------------------
    // Combinational helpers (all from inputs + registered state, feed only the
    // next-state logic, never the outputs)
    // -------------------------------------------------------------------------
    logic [KEY_W-1:0] key_digit;
    logic             accept;
    logic             digit_bad;
    logic             seq_bad;
    logic             last_digit;
    logic             fail_hits_max;
    logic             tamper_evt;
    logic             unlock_expire;
    logic             lockout_expire;
    logic [31:0]      timer_inc;

    // Select the expected digit for the current index.
    always_comb begin
        key_digit = '0;
        for (int i = 0; i < KEY_LEN; i++) begin
            if (idx_q == IDX_W'(i)) begin
                key_digit = KEY[i*KEY_W +: KEY_W];
            end
        end
    end

    always_comb begin
        accept         = key_strobe & ~strobe_prev_q;
        digit_bad      = (key_in != key_digit);
        // The sticky flag carries earlier mismatches; in LOCKED it is always
        // clear, so this also covers a single-digit key evaluated from LOCKED.
        seq_bad        = mismatch_q | digit_bad;
        // idx is 0 in LOCKED, so this is true there only for KEY_LEN = 1.
        last_digit     = (idx_q == LAST_IDX);
        fail_hits_max  = (({1'b0, fail_cnt_q} + 9'd1) == FAIL_LIMIT);
        tamper_evt     = (tamper_in != tamper_prev_q);
        unlock_expire  = (UNLOCK_CYC != 0) && (timer_q == UNLOCK_LAST);
        lockout_expire = (timer_q == LOCKOUT_LAST);
        // Saturating increment: the timer never wraps back into a match.
        timer_inc      = (timer_q == 32'hFFFF_FFFF) ? timer_q : (timer_q + 32'd1);
    end

    // -------------------------------------------------------------------------
    // Main FSM and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // The tamper reference follows the bus in every branch, including
        // reset and power-off, so releasing either never looks like a toggle.
        tamper_prev_q <= tamper_in;

        if (!ena) begin
            // Power-state off: full clear, BRICK included.
            power_q       <= 1'b0;
            state_q       <= ST_LOCKED;
            idx_q         <= '0;
            mismatch_q    <= 1'b0;
            fail_cnt_q    <= '0;
            timer_q       <= '0;
            strobe_prev_q <= 1'b0;
        end else if (!rst_n) begin
            // Reset drops any partial sequence without counting a fail, but a
            // latched BRICK survives it.
            power_q       <= 1'b1;
            if (state_q != ST_BRICK) begin
                state_q <= ST_LOCKED;
            end
            idx_q         <= '0;
            mismatch_q    <= 1'b0;
            fail_cnt_q    <= '0;
            timer_q       <= '0;
            strobe_prev_q <= 1'b0;
        end else begin
            power_q       <= 1'b1;
            strobe_prev_q <= key_strobe;

            if (tamper_evt) begin
                // Tamper outranks everything below it, including a final
                // correct digit on the same edge.
                state_q    <= ST_BRICK;
                idx_q      <= '0;
                mismatch_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_LOCKED, ST_COLLECT: begin
                        if (accept) begin
                            if (last_digit) begin
                                // Sequence complete: evaluate and restart.
                                idx_q      <= '0;
                                mismatch_q <= 1'b0;
                                if (!seq_bad) begin
                                    state_q    <= ST_UNLOCKED;
                                    fail_cnt_q <= '0;
                                    timer_q    <= '0;
                                end else if (fail_hits_max) begin
                                    state_q    <= ST_LOCKOUT;
                                    fail_cnt_q <= fail_cnt_q + 8'd1;
                                    timer_q    <= '0;
                                end else begin
                                    state_q    <= ST_LOCKED;
                                    fail_cnt_q <= fail_cnt_q + 8'd1;
                                end
                            end else begin
                                state_q    <= ST_COLLECT;
                                idx_q      <= idx_q + 1'b1;
                                mismatch_q <= seq_bad;
                            end
                        end
                    end

                    ST_UNLOCKED: begin
                        if (relock || unlock_expire) begin
                            state_q <= ST_LOCKED;
                            timer_q <= '0;
                        end else begin
                            timer_q <= timer_inc;
                        end
                    end

                    ST_LOCKOUT: begin
                        if (lockout_expire) begin
                            state_q    <= ST_LOCKED;
                            fail_cnt_q <= '0;
                            timer_q    <= '0;
                        end else begin
                            timer_q <= timer_inc;
                        end
                    end

                    ST_BRICK: begin
                        // Deaf to everything but ena.
                        state_q <= ST_BRICK;
                    end

                    default: begin
                        state_q    <= ST_LOCKED;
                        idx_q      <= '0;
                        mismatch_q <= 1'b0;
                        timer_q    <= '0;
                    end
                endcase
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output decode (registered state only)
    // -------------------------------------------------------------------------
    logic [7:0] fail_thermo;

    // fail_cnt ones from bit 0, saturating at eight lit positions.
    always_comb begin
        fail_thermo = '0;
        for (int i = 0; i < 8; i++) begin
            fail_thermo[i] = (fail_cnt_q > 8'(i));
        end
    end

    always_comb begin
        seg_out  = SEG_OFF;
        glow_out = 8'h00;
        unlocked = 1'b0;
        bricked  = 1'b0;
        if (power_q) begin
            case (state_q)
                ST_LOCKED: begin
                    seg_out  = SEG_LOCKED;
                    glow_out = fail_thermo;
                end
                ST_COLLECT: begin
                    seg_out  = SEG_COLLECT;
                    glow_out = fail_thermo;
                end
                ST_UNLOCKED: begin
                    seg_out  = SEG_UNLOCKED;
                    glow_out = 8'hFF;
                    unlocked = 1'b1;
                end
                ST_LOCKOUT: begin
                    seg_out  = SEG_LOCKOUT;
                end
                ST_BRICK: begin
                    seg_out  = SEG_BRICK;
                    bricked  = 1'b1;
                end
                default: begin
                    seg_out  = SEG_OFF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vaelix_sequence_gate.sv
// -----------------------------------------------------------------------------
// tb_vaelix_sequence_gate
//
// Directed bench for vaelix_sequence_gate with the default key (digit 0 is
// KEY[7:0] = 0x17, so the correct entry order is 17, C3, 5A, B6),
// LOCKOUT_CYC = 16 and UNLOCK_CYC = 32. Inputs change #1 after each rising
// edge, outputs are sampled at that same point, away from the active edge.
// -----------------------------------------------------------------------------
module tb_vaelix_sequence_gate;

    localparam int KEY_W    = 8;
    localparam int TAMPER_W = 7;

    // ---------------------------------------------------------------- clock
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- DUT io
    logic                rst_n;
    logic                ena;
    logic [KEY_W-1:0]    key_in;
    logic                key_strobe;
    logic                relock;
    logic [TAMPER_W-1:0] tamper_in;
    logic [7:0]          seg_out;
    logic [7:0]          glow_out;
    logic                unlocked;
    logic                bricked;

    vaelix_sequence_gate #(
        .KEY_W       (8),
        .KEY_LEN     (4),
        .KEY         (32'hB65AC317),
        .MAX_FAIL    (3),
        .LOCKOUT_CYC (16),
        .UNLOCK_CYC  (32),
        .TAMPER_W    (7)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .key_in     (key_in),
        .key_strobe (key_strobe),
        .relock     (relock),
        .tamper_in  (tamper_in),
        .seg_out    (seg_out),
        .glow_out   (glow_out),
        .unlocked   (unlocked),
        .bricked    (bricked)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // ---------------------------------------------------------------- drivers
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One digit: strobe high for one edge, then low for one edge.
    task automatic press(input logic [KEY_W-1:0] d);
        key_in     = d;
        key_strobe = 1'b1;
        tick(1);
        key_strobe = 1'b0;
        tick(1);
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        ena = 1'b0; rst_n = 1'b0; key_in = '0; key_strobe = 1'b0;
        relock = 1'b0; tamper_in = '0;
        tick(2);
        tests_run++;
        if (seg_out !== 8'hFF) begin
            tests_failed++;
            $display("FAIL reset_off_seg: got %h want %h", seg_out, 8'hFF);
        end
        ena = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        tests_run++;
        if (seg_out !== 8'hC7) begin
            tests_failed++;
            $display("FAIL reset_seg: got %h want %h", seg_out, 8'hC7);
        end
        tests_run++;
        if (glow_out !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_glow: got %h want %h", glow_out, 8'h00);
        end
        tests_run++;
        if ({unlocked, bricked} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b want %b", {unlocked, bricked}, 2'b00);
        end
    endtask

    task automatic test_unlock();
        press(8'h17);
        tests_run++;
        if (seg_out !== 8'hBF) begin
            tests_failed++;
            $display("FAIL unlock_first_digit_seg: got %h want %h", seg_out, 8'hBF);
        end
        press(8'hC3);
        press(8'h5A);
        press(8'hB6);
        // One edge has passed since UNLOCKED was entered.
        tests_run++;
        if (seg_out !== 8'hC1) begin
            tests_failed++;
            $display("FAIL unlock_seg: got %h want %h", seg_out, 8'hC1);
        end
        tests_run++;
        if (glow_out !== 8'hFF || unlocked !== 1'b1) begin
            tests_failed++;
            $display("FAIL unlock_glow_flag: got %h/%b want %h/%b", glow_out, unlocked, 8'hFF, 1'b1);
        end
        tick(30);  // 31 edges after entry: still open
        tests_run++;
        if (seg_out !== 8'hC1) begin
            tests_failed++;
            $display("FAIL unlock_window_31: got %h want %h", seg_out, 8'hC1);
        end
        tick(1);   // 32 edges after entry: relocked
        tests_run++;
        if (seg_out !== 8'hC7 || unlocked !== 1'b0) begin
            tests_failed++;
            $display("FAIL unlock_window_32: got %h/%b want %h/%b", seg_out, unlocked, 8'hC7, 1'b0);
        end
    endtask

    task automatic test_fail_lockout();
        logic [7:0] wrong [4];
        logic [7:0] glow_exp [2];
        wrong[0] = 8'hB6; wrong[1] = 8'h00; wrong[2] = 8'hC3; wrong[3] = 8'h17;
        glow_exp[0] = 8'h01; glow_exp[1] = 8'h03;
        for (int r = 0; r < 2; r++) begin
            for (int d = 0; d < 4; d++) press(wrong[d]);
            tests_run++;
            if (seg_out !== 8'hC7 || glow_out !== glow_exp[r]) begin
                tests_failed++;
                $display("FAIL fail_round%0d: got %h/%h want %h/%h", r, seg_out, glow_out, 8'hC7, glow_exp[r]);
            end
        end
        press(wrong[0]);
        tests_run++;
        if (seg_out !== 8'hBF || glow_out !== 8'h03) begin
            tests_failed++;
            $display("FAIL fail_collect_glow: got %h/%h want %h/%h", seg_out, glow_out, 8'hBF, 8'h03);
        end
        for (int d = 1; d < 4; d++) press(wrong[d]);
        // LOCKOUT entered one edge ago.
        tests_run++;
        if (seg_out !== 8'h86 || glow_out !== 8'h00) begin
            tests_failed++;
            $display("FAIL lockout_enter: got %h/%h want %h/%h", seg_out, glow_out, 8'h86, 8'h00);
        end
        press(8'h17);  // ignored, edges 2..3
        tests_run++;
        if (seg_out !== 8'h86) begin
            tests_failed++;
            $display("FAIL lockout_strobe_ignored: got %h want %h", seg_out, 8'h86);
        end
        tick(12);      // edge 15
        tests_run++;
        if (seg_out !== 8'h86) begin
            tests_failed++;
            $display("FAIL lockout_edge15: got %h want %h", seg_out, 8'h86);
        end
        tick(1);       // edge 16
        tests_run++;
        if (seg_out !== 8'hC7 || glow_out !== 8'h00) begin
            tests_failed++;
            $display("FAIL lockout_exit: got %h/%h want %h/%h", seg_out, glow_out, 8'hC7, 8'h00);
        end
    endtask

    task automatic test_held_strobe();
        key_in     = 8'h17;
        key_strobe = 1'b1;
        tick(10);
        tests_run++;
        if (seg_out !== 8'hBF) begin
            tests_failed++;
            $display("FAIL held_strobe_seg: got %h want %h", seg_out, 8'hBF);
        end
        key_strobe = 1'b0;
        tick(1);
        // Only digit 0 was consumed, so three more digits complete the key.
        press(8'hC3);
        tests_run++;
        if (seg_out !== 8'hBF) begin
            tests_failed++;
            $display("FAIL held_strobe_mid: got %h want %h", seg_out, 8'hBF);
        end
        press(8'h5A);
        press(8'hB6);
        tests_run++;
        if (unlocked !== 1'b1) begin
            tests_failed++;
            $display("FAIL held_strobe_unlock: got %b want %b", unlocked, 1'b1);
        end
    endtask

    task automatic test_relock();
        press(8'h17);  // ignored while open
        tests_run++;
        if (seg_out !== 8'hC1) begin
            tests_failed++;
            $display("FAIL open_strobe_ignored: got %h want %h", seg_out, 8'hC1);
        end
        relock = 1'b1;
        tick(1);
        relock = 1'b0;
        tests_run++;
        if (seg_out !== 8'hC7 || unlocked !== 1'b0) begin
            tests_failed++;
            $display("FAIL relock: got %h/%b want %h/%b", seg_out, unlocked, 8'hC7, 1'b0);
        end
        tick(1);
    endtask

    task automatic test_reset_mid_sequence();
        for (int d = 0; d < 4; d++) press(8'hB6);
        tests_run++;
        if (glow_out !== 8'h01) begin
            tests_failed++;
            $display("FAIL pre_reset_fail: got %h want %h", glow_out, 8'h01);
        end
        press(8'h17);
        press(8'hC3);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        tests_run++;
        if (seg_out !== 8'hC7 || glow_out !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_mid_seq: got %h/%h want %h/%h", seg_out, glow_out, 8'hC7, 8'h00);
        end
        // Partial entry was discarded: a fresh full key opens.
        press(8'h17); press(8'hC3); press(8'h5A); press(8'hB6);
        tests_run++;
        if (unlocked !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_seq_fresh: got %b want %b", unlocked, 1'b1);
        end
    endtask

    task automatic test_back_to_back();
        relock = 1'b1;
        tick(1);
        relock = 1'b0;
        press(8'h17); press(8'hC3); press(8'h5A); press(8'hB6);
        tests_run++;
        if (seg_out !== 8'hC1) begin
            tests_failed++;
            $display("FAIL back_to_back_unlock: got %h want %h", seg_out, 8'hC1);
        end
        relock = 1'b1;
        tick(1);
        relock = 1'b0;
    endtask

    task automatic test_tamper();
        press(8'h17);
        tests_run++;
        if (seg_out !== 8'hBF) begin
            tests_failed++;
            $display("FAIL tamper_pre_collect: got %h want %h", seg_out, 8'hBF);
        end
        tamper_in = tamper_in ^ 7'h08;
        tick(1);
        tests_run++;
        if (seg_out !== 8'h00 || bricked !== 1'b1) begin
            tests_failed++;
            $display("FAIL tamper_brick: got %h/%b want %h/%b", seg_out, bricked, 8'h00, 1'b1);
        end
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        press(8'h17);
        tests_run++;
        if (seg_out !== 8'h00 || bricked !== 1'b1) begin
            tests_failed++;
            $display("FAIL brick_survives_reset: got %h/%b want %h/%b", seg_out, bricked, 8'h00, 1'b1);
        end
        ena = 1'b0;
        tick(1);
        tests_run++;
        if (seg_out !== 8'hFF || glow_out !== 8'h00 || bricked !== 1'b0) begin
            tests_failed++;
            $display("FAIL ena_off: got %h/%h/%b want %h/%h/%b", seg_out, glow_out, bricked, 8'hFF, 8'h00, 1'b0);
        end
        ena = 1'b1;
        tick(1);
        tests_run++;
        if (seg_out !== 8'hC7) begin
            tests_failed++;
            $display("FAIL ena_on: got %h want %h", seg_out, 8'hC7);
        end
    endtask

    task automatic test_tamper_final_digit();
        int saw_unlock;
        saw_unlock = 0;
        press(8'h17); press(8'hC3); press(8'h5A);
        key_in     = 8'hB6;
        key_strobe = 1'b1;
        tamper_in  = tamper_in ^ 7'h01;
        tick(1);
        if (unlocked !== 1'b0) saw_unlock++;
        tests_run++;
        if (seg_out !== 8'h00 || bricked !== 1'b1) begin
            tests_failed++;
            $display("FAIL tamper_vs_final: got %h/%b want %h/%b", seg_out, bricked, 8'h00, 1'b1);
        end
        key_strobe = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick(1);
            if (unlocked !== 1'b0) saw_unlock++;
        end
        tests_run++;
        if (saw_unlock !== 0) begin
            tests_failed++;
            $display("FAIL tamper_vs_final_unlock: got %0d want %0d", saw_unlock, 0);
        end
        ena = 1'b0;
        tick(1);
        ena = 1'b1;
        tick(1);
    endtask

    // ---------------------------------------------------------------- main
    initial begin
        test_reset();
        test_unlock();
        test_fail_lockout();
        test_held_strobe();
        test_relock();
        test_reset_mid_sequence();
        test_back_to_back();
        test_tamper();
        test_tamper_final_digit();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
